// File: rtl/div_error_accumulator_pkg.sv
// div_error_accumulator_pkg: shared state enum, divider widths and sizing helpers.
package div_error_accumulator_pkg;
  typedef enum logic [1:0] {IDLE, DIV, ACC} state_t;
  localparam int N_W = 16;
  localparam int D_W = 8;
  function automatic int sum_w(input int n_samples);
    return D_W + $clog2(n_samples);
  endfunction
  function automatic logic [8:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] x;
    logic [8:0] y;
    x = {1'b0, a};
    y = {1'b0, b};
    return x >= y ? x - y : y - x;
  endfunction
endpackage

// File: rtl/div_error_accumulator_div.sv
// div_restoring_seq: 8-cycle MSB-first restoring divider for n[15:0] / d[7:0] without quotient overflow.
module div_restoring_seq
  import div_error_accumulator_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N_W-1:0] n,
  input  logic [D_W-1:0] d,
  output logic           done,
  output logic [7:0]     q_exact,
  output logic [7:0]     r_exact
);
  logic [8:0] rem;
  logic [7:0] lo, dv, q;
  logic [2:0] cnt;
  logic busy;
  logic [9:0] t;
  logic take;
  assign t = {rem, lo[7]};
  assign take = t >= {2'b0, dv};
  assign done = busy && cnt == 3'd7;
  assign q_exact = q;
  assign r_exact = 8'(rem);
  always_ff @(posedge clk) begin
    if (rst) begin
      rem <= '0;
      lo <= '0;
      dv <= '0;
      q <= '0;
      cnt <= '0;
      busy <= 1'b0;
    end else if (start) begin
      rem <= {1'b0, n[15:8]};
      lo <= n[7:0];
      dv <= d;
      q <= '0;
      cnt <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      rem <= 9'(take ? t - {2'b0, dv} : t);
      lo <= {lo[6:0], 1'b0};
      q <= {q[6:0], take};
      cnt <= cnt + 3'd1;
      busy <= cnt != 3'd7;
    end
  end
endmodule

// File: rtl/div_error_accumulator.sv
// div_error_accumulator: compares an approximate divider's quotient/remainder against an exact
// sequential divider and reports per-batch error statistics.
module div_error_accumulator
  import div_error_accumulator_pkg::*;
#(
  parameter int N_SAMPLES = 256,
  parameter int SUM_W = sum_w(N_SAMPLES)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [N_W-1:0]                 n,
  input  logic [D_W-1:0]                 d,
  input  logic [7:0]                     q_apx,
  input  logic [7:0]                     r_apx,
  output logic                           res_valid,
  output logic [SUM_W-1:0]               sum_q_err,
  output logic [SUM_W-1:0]               sum_r_err,
  output logic [7:0]                     max_q_err,
  output logic [$clog2(N_SAMPLES):0]     mis_count,
  output logic [$clog2(N_SAMPLES):0]     ovf_count
);
  localparam int CNT_W = $clog2(N_SAMPLES) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_SAMPLES - 1);
  state_t state, state_nxt;
  logic accept, ovf_in, ovf_r, div_done, last;
  logic [7:0] q_apx_r, r_apx_r, q_exact, r_exact, acc_max, nxt_max;
  logic [8:0] q_err, r_err;
  logic [SUM_W-1:0] acc_sq, acc_sr, nxt_sq, nxt_sr;
  logic [CNT_W-1:0] acc_mis, acc_ovf, nxt_mis, nxt_ovf, batch_cnt;
  assign in_ready = state == IDLE;
  assign accept = in_valid && in_ready;
  // Such samples would need a quotient wider than 8 bits, so they bypass the divider.
  assign ovf_in = d == '0 || n[15:8] >= d;
  assign last = batch_cnt == LAST;
  div_restoring_seq u_div (
    .clk(clk),
    .rst(rst),
    .start(accept && !ovf_in),
    .n(n),
    .d(d),
    .done(div_done),
    .q_exact(q_exact),
    .r_exact(r_exact)
  );
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = accept ? (ovf_in ? ACC : DIV) : IDLE;
      DIV: state_nxt = div_done ? ACC : DIV;
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
    q_err = abs_diff(q_exact, q_apx_r);
    r_err = abs_diff(r_exact, r_apx_r);
    nxt_sq = acc_sq + (ovf_r ? '0 : SUM_W'(q_err));
    nxt_sr = acc_sr + (ovf_r ? '0 : SUM_W'(r_err));
    nxt_max = (!ovf_r && q_err > {1'b0, acc_max}) ? 8'(q_err) : acc_max;
    nxt_mis = acc_mis + CNT_W'(!ovf_r && q_exact != q_apx_r);
    nxt_ovf = acc_ovf + CNT_W'(ovf_r);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ovf_r <= 1'b0;
      q_apx_r <= '0;
      r_apx_r <= '0;
      batch_cnt <= '0;
      acc_sq <= '0;
      acc_sr <= '0;
      acc_max <= '0;
      acc_mis <= '0;
      acc_ovf <= '0;
      res_valid <= 1'b0;
      sum_q_err <= '0;
      sum_r_err <= '0;
      max_q_err <= '0;
      mis_count <= '0;
      ovf_count <= '0;
    end else begin
      state <= state_nxt;
      res_valid <= state == ACC && last;
      if (accept) begin
        ovf_r <= ovf_in;
        q_apx_r <= q_apx;
        r_apx_r <= r_apx;
      end
      if (state == ACC) begin
        batch_cnt <= last ? '0 : batch_cnt + CNT_W'(1);
        acc_sq <= last ? '0 : nxt_sq;
        acc_sr <= last ? '0 : nxt_sr;
        acc_max <= last ? '0 : nxt_max;
        acc_mis <= last ? '0 : nxt_mis;
        acc_ovf <= last ? '0 : nxt_ovf;
        if (last) begin
          sum_q_err <= nxt_sq;
          sum_r_err <= nxt_sr;
          max_q_err <= nxt_max;
          mis_count <= nxt_mis;
          ovf_count <= nxt_ovf;
        end
      end
    end
  end
endmodule
